// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the external memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin picker: rotate requests past ptr, take the lowest set bit, rotate back.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  logic [PW:0]          shamt;
  logic [2*N_REQ-1:0]   rot_wide;
  logic [2*N_REQ-1:0]   back_wide;
  logic [N_REQ-1:0]     rot;
  logic [N_REQ-1:0]     rot_gnt;

  // Search starts one past the last owner, so shift by ptr+1 (may equal N_REQ).
  assign shamt    = {1'b0, ptr} + 1'b1;
  assign rot_wide = {req, req} >> shamt;
  assign rot      = rot_wide[N_REQ-1:0];

  always_comb begin
    rot_gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_gnt    = '0;
        rot_gnt[i] = 1'b1;
      end
    end
  end

  assign back_wide = {{N_REQ{1'b0}}, rot_gnt} << shamt;
  assign gnt       = back_wide[N_REQ-1:0] | back_wide[2*N_REQ-1:N_REQ];
  assign valid     = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one byte-serial memory sequencer, one transaction per grant.
// Optional MEM_ARB_LOCK_EN adds a lock port that re-grants the owner for atomic RMW.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [DW-1:0]      rdata,
  output logic               m_req,
  output logic               m_we,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_wdata,
  input  logic               m_done,
  input  logic [DW-1:0]      m_rdata
`ifdef MEM_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]   lock
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state, state_next;
  logic [PW-1:0]    ptr, owner, ptr_after, sel_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic             start, finish;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_idx   = PW'(i);
      end
    end
  end

  // A locked owner parks the pointer just before itself so it wins the next IDLE.
`ifdef MEM_ARB_LOCK_EN
  assign ptr_after = (|(lock & gnt)) ?
                     ((owner == '0) ? PW'(N_REQ - 1) : owner - 1'b1) : owner;
`else
  assign ptr_after = owner;
`endif

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          start      = 1'b1;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (m_done) begin
          finish     = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      ptr     <= PW'(N_REQ - 1);
      owner   <= '0;
      gnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        gnt     <= pick_gnt;
        owner   <= sel_idx;
        m_req   <= 1'b1;
        m_we    <= sel_we;
        m_addr  <= sel_addr;
        m_wdata <= sel_wdata;
      end
      if (finish) begin
        m_req <= 1'b0;
        gnt   <= '0;
        ptr   <= ptr_after;
      end
    end
  end

  // Completion is reported in the same cycle as the sequencer's pulse.
  assign done  = (state == ARB_BUSY && m_done) ? gnt : '0;
  assign rdata = (state == ARB_BUSY && m_done) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (N_REQ=2); lock steps run only with MEM_ARB_LOCK_EN.
module tb_mem_bus_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 16;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req, we, gnt, done;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [DW-1:0]     rdata, m_wdata, m_rdata;
  logic              m_req, m_we, m_done;
  logic [AW-1:0]     m_addr;
`ifdef MEM_ARB_LOCK_EN
  logic [N_REQ-1:0]  lock;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .done    (done),
    .rdata   (rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_done  (m_done),
    .m_rdata (m_rdata)
`ifdef MEM_ARB_LOCK_EN
    ,
    .lock    (lock)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    req   = r;
    we    = w;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sequencer answers after lat cycles; keep_req models requesters dropping req on done.
  task automatic complete_txn(input int lat, input logic [7:0] rd,
                              input logic [1:0] exp_done, input logic [1:0] keep_req,
                              input string tag);
    repeat (lat) tick();
    m_done  = 1'b1;
    m_rdata = rd;
    #1;
    checkOutput({tag, " done"}, 32'(done), 32'(exp_done));
    checkOutput({tag, " rdata"}, 32'(rdata), 32'(rd));
    req = req & keep_req;
    tick();
    m_done  = 1'b0;
    m_rdata = '0;
    #1;
    checkOutput({tag, " done cleared"}, 32'(done), 32'h0);
    checkOutput({tag, " m_req cleared"}, 32'(m_req), 32'h0);
    checkOutput({tag, " gnt cleared"}, 32'(gnt), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    m_done  = 1'b0;
    m_rdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    m_done  = 1'b0;
    m_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
    lock = 2'b00;
`endif
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    tick();
    tick();
    checkOutput("reset gnt", 32'(gnt), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset m_req", 32'(m_req), 32'h0);
    checkOutput("reset m_we", 32'(m_we), 32'h0);
    checkOutput("reset m_addr", 32'(m_addr), 32'h0);
    checkOutput("reset m_wdata", 32'(m_wdata), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read from requester 0
    applyStimulus(2'b01, 2'b00, 16'h1234, 16'h0, 8'h0, 8'h0);
    #1;
    checkOutput("t1 m_req before edge", 32'(m_req), 32'h0);
    tick();
    checkOutput("t1 m_req", 32'(m_req), 32'h1);
    checkOutput("t1 gnt", 32'(gnt), 32'h1);
    checkOutput("t1 m_addr", 32'(m_addr), 32'h1234);
    checkOutput("t1 m_we", 32'(m_we), 32'h0);
    complete_txn(4, 8'hA5, 2'b01, 2'b00, "t1");

    // Both requesting: strict alternation starting at 0
    do_reset();
    applyStimulus(2'b11, 2'b00, 16'h1000, 16'h2000, 8'h0, 8'h0);
    tick();
    checkOutput("t2 gnt a", 32'(gnt), 32'h1);
    checkOutput("t2 addr a", 32'(m_addr), 32'h1000);
    complete_txn(2, 8'h11, 2'b01, 2'b11, "t2a");
    tick();
    checkOutput("t2 gnt b", 32'(gnt), 32'h2);
    checkOutput("t2 addr b", 32'(m_addr), 32'h2000);
    complete_txn(2, 8'h22, 2'b10, 2'b11, "t2b");
    tick();
    checkOutput("t2 gnt c", 32'(gnt), 32'h1);
    checkOutput("t2 addr c", 32'(m_addr), 32'h1000);
    complete_txn(2, 8'h33, 2'b01, 2'b11, "t2c");
    tick();
    checkOutput("t2 gnt d", 32'(gnt), 32'h2);
    checkOutput("t2 addr d", 32'(m_addr), 32'h2000);
    complete_txn(2, 8'h44, 2'b10, 2'b00, "t2d");

    // Requester 1 write held stable while inputs change mid-BUSY
    applyStimulus(2'b10, 2'b10, 16'h0, 16'hCAFE, 8'h0, 8'h3C);
    tick();
    checkOutput("t3 gnt", 32'(gnt), 32'h2);
    checkOutput("t3 m_we", 32'(m_we), 32'h1);
    checkOutput("t3 m_addr", 32'(m_addr), 32'hCAFE);
    checkOutput("t3 m_wdata", 32'(m_wdata), 32'h3C);
    tick();
    applyStimulus(2'b11, 2'b11, 16'h0BEE, 16'hFFFF, 8'h5A, 8'h77);
    tick();
    checkOutput("t3 m_addr held", 32'(m_addr), 32'hCAFE);
    checkOutput("t3 m_wdata held", 32'(m_wdata), 32'h3C);
    checkOutput("t3 gnt held", 32'(gnt), 32'h2);
    complete_txn(2, 8'h00, 2'b10, 2'b01, "t3");
    tick();
    checkOutput("t3 next gnt", 32'(gnt), 32'h1);
    checkOutput("t3 next m_addr", 32'(m_addr), 32'h0BEE);
    checkOutput("t3 next m_we", 32'(m_we), 32'h1);
    checkOutput("t3 next m_wdata", 32'(m_wdata), 32'h5A);

    // Asynchronous reset in the middle of requester 0's transaction
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t4 m_req", 32'(m_req), 32'h0);
    checkOutput("t4 gnt", 32'(gnt), 32'h0);
    checkOutput("t4 m_we", 32'(m_we), 32'h0);
    checkOutput("t4 m_addr", 32'(m_addr), 32'h0);
    checkOutput("t4 m_wdata", 32'(m_wdata), 32'h0);
    applyStimulus(2'b11, 2'b00, 16'h0BEE, 16'hCAFE, 8'h0, 8'h0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t4 first gnt", 32'(gnt), 32'h1);
    checkOutput("t4 first m_addr", 32'(m_addr), 32'h0BEE);
    complete_txn(1, 8'h69, 2'b01, 2'b00, "t4");

    // Spurious m_done in IDLE
    applyStimulus(2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    tick();
    m_done  = 1'b1;
    m_rdata = 8'hFF;
    #1;
    checkOutput("t5 done", 32'(done), 32'h0);
    tick();
    m_done  = 1'b0;
    m_rdata = '0;
    #1;
    checkOutput("t5 m_req", 32'(m_req), 32'h0);
    checkOutput("t5 gnt", 32'(gnt), 32'h0);
    applyStimulus(2'b01, 2'b00, 16'h4321, 16'h0, 8'h0, 8'h0);
    tick();
    checkOutput("t5 gnt after", 32'(gnt), 32'h1);
    checkOutput("t5 m_addr after", 32'(m_addr), 32'h4321);
    complete_txn(1, 8'h12, 2'b01, 2'b00, "t5");

`ifdef MEM_ARB_LOCK_EN
    // Lock keeps requester 0 for a second access, then round-robin resumes
    do_reset();
    lock = 2'b01;
    applyStimulus(2'b11, 2'b00, 16'hA000, 16'hB000, 8'h0, 8'h0);
    tick();
    checkOutput("t6 gnt a", 32'(gnt), 32'h1);
    complete_txn(1, 8'h01, 2'b01, 2'b11, "t6a");
    tick();
    checkOutput("t6 gnt b", 32'(gnt), 32'h1);
    checkOutput("t6 addr b", 32'(m_addr), 32'hA000);
    lock = 2'b00;
    complete_txn(1, 8'h02, 2'b01, 2'b11, "t6b");
    tick();
    checkOutput("t6 gnt c", 32'(gnt), 32'h2);
    checkOutput("t6 addr c", 32'(m_addr), 32'hB000);
    complete_txn(1, 8'h03, 2'b10, 2'b00, "t6c");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
